// File: rtl/airlock_scheduler_if.sv
// Signal bundle between the bay/chamber side (master) and the airlock scheduler (slave).
interface airlock_scheduler_if;
  logic arriveReq;
  logic departReq;
  logic pressurized;
  logic evacuated;
  logic innerDoor;
  logic outerDoor;
  logic arriving;
  logic departing;
  logic pressurizeCmd;
  logic evacuateCmd;
  logic openInner;
  logic openOuter;

  modport master (
    output arriveReq, departReq, pressurized, evacuated, innerDoor, outerDoor,
    input  arriving, departing, pressurizeCmd, evacuateCmd, openInner, openOuter
  );

  modport slave (
    input  arriveReq, departReq, pressurized, evacuated, innerDoor, outerDoor,
    output arriving, departing, pressurizeCmd, evacuateCmd, openInner, openOuter
  );
endinterface

// File: rtl/airlock_scheduler.sv
// Airlock scheduler: round-robin arbitration of the single chamber and sequencing of
// pressure, door and dwell steps for each arrival/departure transit.
module airlock_scheduler #(
  parameter int WAIT_CYC = 5,
  parameter int CW       = 4
) (
  input logic          clk,
  input logic          rst,
  airlock_scheduler_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    PREP   = 4'd1,
    OPEN1  = 4'd2,
    HOLD1  = 4'd3,
    CLOSE1 = 4'd4,
    XFER   = 4'd5,
    OPEN2  = 4'd6,
    HOLD2  = 4'd7,
    CLOSE2 = 4'd8
  } state_e;

  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYC - 1);

  state_e        state_r;
  logic          dir_r;
  logic          last_served_r;
  logic [CW-1:0] cnt_r;
  // {pressurizeCmd, evacuateCmd, openInner, openOuter, arriving, departing}
  logic [5:0]    outs_r;

  logic          req_dir_s;
  logic          prep_ok_s;
  logic          xfer_ok_s;
  logic          first_open_s;
  logic          second_open_s;

  // Moore output pattern of a state; arrival opens the outer side first, departure the inner.
  function automatic logic [5:0] decode(input state_e st, input logic arr);
    logic [5:0] o;
    o = 6'b000000;
    case (st)
      IDLE:           o = 6'b000000;
      PREP:           o[5:4] = arr ? 2'b01 : 2'b10;
      OPEN1, HOLD1:   o[3:2] = arr ? 2'b01 : 2'b10;
      CLOSE1, CLOSE2: o[3:2] = 2'b00;
      XFER:           o[5:4] = arr ? 2'b10 : 2'b01;
      OPEN2, HOLD2:   o[3:2] = arr ? 2'b10 : 2'b01;
      default:        o = 6'b000000;
    endcase
    if (st != IDLE) begin
      o[1:0] = arr ? 2'b10 : 2'b01;
    end else begin
      o[1:0] = 2'b00;
    end
    return o;
  endfunction

  // Sensor conditions expressed relative to the current transit direction.
  always_comb begin
    req_dir_s = (bus.arriveReq && bus.departReq) ? ~last_served_r : bus.arriveReq;
    if (dir_r) begin
      prep_ok_s     = bus.evacuated;
      xfer_ok_s     = bus.pressurized;
      first_open_s  = bus.outerDoor;
      second_open_s = bus.innerDoor;
    end else begin
      prep_ok_s     = bus.pressurized;
      xfer_ok_s     = bus.evacuated;
      first_open_s  = bus.innerDoor;
      second_open_s = bus.outerDoor;
    end
  end

  // Transit sequencer; outputs are loaded with the pattern of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      dir_r         <= 1'b0;
      last_served_r <= 1'b0;
      cnt_r         <= {CW{1'b0}};
      outs_r        <= 6'b000000;
    end else begin
      case (state_r)
        IDLE: if (bus.arriveReq || bus.departReq) begin
          state_r <= PREP;
          dir_r   <= req_dir_s;
          outs_r  <= decode(PREP, req_dir_s);
        end
        PREP: if (prep_ok_s) begin
          state_r <= OPEN1;
          outs_r  <= decode(OPEN1, dir_r);
        end
        OPEN1: if (first_open_s) begin
          state_r <= HOLD1;
          cnt_r   <= {CW{1'b0}};
          outs_r  <= decode(HOLD1, dir_r);
        end
        HOLD1: if (cnt_r == LAST_CNT) begin
          state_r <= CLOSE1;
          cnt_r   <= {CW{1'b0}};
          outs_r  <= decode(CLOSE1, dir_r);
        end else begin
          cnt_r <= cnt_r + 1'b1;
        end
        CLOSE1: if (!first_open_s) begin
          state_r <= XFER;
          outs_r  <= decode(XFER, dir_r);
        end
        XFER: if (xfer_ok_s) begin
          state_r <= OPEN2;
          outs_r  <= decode(OPEN2, dir_r);
        end
        OPEN2: if (second_open_s) begin
          state_r <= HOLD2;
          cnt_r   <= {CW{1'b0}};
          outs_r  <= decode(HOLD2, dir_r);
        end
        HOLD2: if (cnt_r == LAST_CNT) begin
          state_r <= CLOSE2;
          cnt_r   <= {CW{1'b0}};
          outs_r  <= decode(CLOSE2, dir_r);
        end else begin
          cnt_r <= cnt_r + 1'b1;
        end
        CLOSE2: if (!second_open_s) begin
          state_r       <= IDLE;
          last_served_r <= dir_r;
          outs_r        <= 6'b000000;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
          outs_r  <= 6'b000000;
        end
      endcase
    end
  end

  assign bus.pressurizeCmd = outs_r[5];
  assign bus.evacuateCmd   = outs_r[4];
  assign bus.openInner     = outs_r[3];
  assign bus.openOuter     = outs_r[2];
  assign bus.arriving      = outs_r[1];
  assign bus.departing     = outs_r[0];

endmodule

// File: tb/tb_airlock_scheduler.sv
// Self-checking bench for airlock_scheduler: step-table transit model, chamber/door
// environment with configurable response delay, and directed scenarios.
module tb_airlock_scheduler;
  localparam int WAIT_CYC = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;

  airlock_scheduler_if bus_if();

  airlock_scheduler #(.WAIT_CYC(WAIT_CYC), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // environment controls
  int dly = 0;
  bit stuck_inner = 1'b0;
  int p_cnt = 0, i_cnt = 0, o_cnt = 0;

  // outputs as {press, evac, inner, outer, arriving, departing}
  function automatic logic [5:0] douts();
    return {bus_if.pressurizeCmd, bus_if.evacuateCmd, bus_if.openInner,
            bus_if.openOuter, bus_if.arriving, bus_if.departing};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // ---------------- transit model: 8 steps per transit ----------------
  // steps: 0 first pressure, 1 open first door, 2 dwell, 3 close first door,
  //        4 second pressure, 5 open second door, 6 dwell, 7 close second door
  bit m_busy = 1'b0, m_dir = 1'b0, m_last = 1'b0;
  int m_step = 0, m_hold = 0;

  function automatic bit outer_side(input int step, input bit arr);
    return ((step < 4) == arr);
  endfunction

  function automatic bit step_done(input int step, input bit arr, input int hold);
    bit door;
    door = outer_side(step, arr) ? bus_if.outerDoor : bus_if.innerDoor;
    if (step == 0)      return ((step == 0) == arr) ? bus_if.evacuated : bus_if.pressurized;
    else if (step == 4) return arr ? bus_if.pressurized : bus_if.evacuated;
    else if (step == 1 || step == 5) return door;
    else if (step == 3 || step == 7) return !door;
    else return (hold == WAIT_CYC - 1);
  endfunction

  function automatic logic [5:0] model_out();
    logic [5:0] o;
    bit want_vac, outer;
    o = 6'b000000;
    if (m_busy) begin
      o[1:0] = m_dir ? 2'b10 : 2'b01;
      if (m_step == 0 || m_step == 4) begin
        want_vac = ((m_step == 0) == m_dir);
        o[4] = want_vac;
        o[5] = !want_vac;
      end else if (m_step == 1 || m_step == 2 || m_step == 5 || m_step == 6) begin
        outer = outer_side(m_step, m_dir);
        o[2] = outer;
        o[3] = !outer;
      end
    end
    return o;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_step <= 0; m_hold <= 0; m_last <= 1'b0; m_dir <= 1'b0;
    end else if (!m_busy) begin
      if (bus_if.arriveReq || bus_if.departReq) begin
        m_busy <= 1'b1;
        m_step <= 0;
        m_hold <= 0;
        m_dir  <= (bus_if.arriveReq && bus_if.departReq) ? !m_last : bus_if.arriveReq;
      end
    end else if (step_done(m_step, m_dir, m_hold)) begin
      m_hold <= 0;
      if (m_step == 7) begin
        m_busy <= 1'b0;
        m_last <= m_dir;
      end else begin
        m_step <= m_step + 1;
      end
    end else if (m_step == 2 || m_step == 6) begin
      m_hold <= m_hold + 1;
    end
  end

  // ---------------- chamber and door environment ----------------
  initial begin
    bus_if.arriveReq   = 1'b0;
    bus_if.departReq   = 1'b0;
    bus_if.pressurized = 1'b1;
    bus_if.evacuated   = 1'b0;
    bus_if.innerDoor   = 1'b0;
    bus_if.outerDoor   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_if.pressurizeCmd && !bus_if.pressurized) begin
        if (p_cnt >= dly) begin bus_if.pressurized = 1'b1; bus_if.evacuated = 1'b0; p_cnt = 0; end
        else p_cnt++;
      end else if (bus_if.evacuateCmd && !bus_if.evacuated) begin
        if (p_cnt >= dly) begin bus_if.evacuated = 1'b1; bus_if.pressurized = 1'b0; p_cnt = 0; end
        else p_cnt++;
      end else p_cnt = 0;
      if (stuck_inner) begin
        bus_if.innerDoor = 1'b0; i_cnt = 0;
      end else if (bus_if.openInner != bus_if.innerDoor) begin
        if (i_cnt >= dly) begin bus_if.innerDoor = bus_if.openInner; i_cnt = 0; end
        else i_cnt++;
      end else i_cnt = 0;
      if (bus_if.openOuter != bus_if.outerDoor) begin
        if (o_cnt >= dly) begin bus_if.outerDoor = bus_if.openOuter; o_cnt = 0; end
        else o_cnt++;
      end else o_cnt = 0;
    end
  end

  // ---------------- per-cycle compare against model and interlocks ----------------
  initial begin
    logic [5:0] d, e;
    bit bad;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        d = douts();
        e = model_out();
        tests_run++;
        if (d !== e) begin
          tests_failed++;
          $display("FAIL model @%0d: got %b, expected %b", cyc, d, e);
        end
        bad = (d[3] && d[2]) || (d[5] && d[4]) || ((d[5] || d[4]) && (d[3] || d[2])) ||
              (d[3] && !bus_if.pressurized) || (d[2] && !bus_if.evacuated);
        tests_run++;
        if (bad) begin
          tests_failed++;
          $display("FAIL interlock @%0d: outputs %b, pressurized %b, evacuated %b",
                   cyc, d, bus_if.pressurized, bus_if.evacuated);
        end
      end
    end
  end

  // ---------------- directed scenarios ----------------
  logic [5:0] o;
  int n, fe, fo, fp, fi, no, ni;
  bit dirs[3];

  task automatic wait_any(input string name, input logic [5:0] mask, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if ((douts() & mask) != 6'b000000) return;
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic [5:0] w;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      w = douts();
      if (w[1:0] == 2'b00) return;
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state held while no requests
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (douts() == 6'b000000) n++;
    end
    chk("reset_idle_cycles", n, 10);

    // arrival with sensors responding in the third cycle of each wait
    dly = 2;
    bus_if.arriveReq = 1'b1;
    wait_any("arr_start", 6'b000010, 5);
    bus_if.arriveReq = 1'b0;
    n = 0; fe = -1; fo = -1; fp = -1; fi = -1; no = 0; ni = 0;
    o = douts();
    while (o[1] && n < 200) begin
      if (o[4] && fe < 0) fe = n;
      if (o[2] && fo < 0) fo = n;
      if (o[5] && fp < 0) fp = n;
      if (o[3] && fi < 0) fi = n;
      if (o[2]) no++;
      if (o[3]) ni++;
      n++;
      @(negedge clk);
      o = douts();
    end
    chk("arr_len", n, 28);
    chk("arr_outer_cycles", no, 8);
    chk("arr_inner_cycles", ni, 8);
    chk("arr_first_evac", fe, 0);
    chk("arr_first_outer", fo, 3);
    chk("arr_first_press", fp, 14);
    chk("arr_first_inner", fi, 17);
    chk("arr_idle_after", int'(o), 0);

    // departure with instant sensors
    dly = 0;
    bus_if.departReq = 1'b1;
    wait_any("dep_start", 6'b000001, 5);
    bus_if.departReq = 1'b0;
    n = 0;
    o = douts();
    while (o[0] && n < 200) begin
      n++;
      @(negedge clk);
      o = douts();
    end
    chk("dep_len", n, 16);
    chk("dep_idle_after", int'(o), 0);

    // tie after reset: arrival, departure, arrival, back-to-back
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_if.arriveReq = 1'b1;
    bus_if.departReq = 1'b1;
    for (int t = 0; t < 3; t++) begin
      wait_any("tie_start", 6'b000011, (t == 0) ? 5 : 1);
      o = douts();
      dirs[t] = o[1];
      if (t == 2) begin
        bus_if.arriveReq = 1'b0;
        bus_if.departReq = 1'b0;
      end
      wait_idle("tie_end", 100);
    end
    chk("tie_dir0", int'(dirs[0]), 1);
    chk("tie_dir1", int'(dirs[1]), 0);
    chk("tie_dir2", int'(dirs[2]), 1);

    // reset in the middle of the first dwell
    bus_if.arriveReq = 1'b1;
    wait_any("mid_open", 6'b000100, 10);
    bus_if.arriveReq = 1'b0;
    repeat (2) @(negedge clk);
    o = douts();
    chk("mid_in_hold", int'(o), int'(6'b000110));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_outs", int'(douts()), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_reset_hold", int'(douts()), 0);
    bus_if.arriveReq = 1'b1;
    @(negedge clk);
    chk("mid_restart_prep", int'(douts()), int'(6'b010010));
    bus_if.arriveReq = 1'b0;
    wait_idle("mid_end", 100);

    // departure with the inner door sensor stuck closed
    stuck_inner = 1'b1;
    bus_if.departReq = 1'b1;
    wait_any("stuck_start", 6'b000001, 5);
    bus_if.departReq = 1'b0;
    wait_any("stuck_open", 6'b001000, 10);
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (douts() == 6'b001001) n++;
    end
    chk("stuck_hold_cycles", n, 50);
    stuck_inner = 1'b0;
    wait_idle("stuck_end", 100);
    chk("stuck_idle_after", int'(douts()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
